hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Decides, every cycle, whether the ID/EX bubble mux receives Stall or NOP; Stall and NOP zero all ID control into ID/EX.
//  Also drives PC write-enable, IF/ID write/flush and the back-end freeze.
//  Handles load-use hazards, EX-resolved redirects, IM wait and DM wait.
//  Tracks wrong-path fetches still in flight across IM wait.
// PARAMETERS
//  CNT_W    32  width of performance counters (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  IDEX_MemRead   in   1      instruction in EX is a load
//  IDEX_rd        in   5      destination register of instruction in EX
//  IFID_rs1       in   5      rs1 of instruction in ID
//  IFID_rs2       in   5      rs2 of instruction in ID
//  IFID_use_rs1   in   1      ID instruction reads rs1
//  IFID_use_rs2   in   1      ID instruction reads rs2
//  EX_redirect    in   1      taken branch/JAL/JALR resolved in EX
//  IM_stall       in   1      instruction fetch not yet returned
//  DM_stall       in   1      data access not yet complete
//  Stall          out  1      to bubble mux: load-use / fetch-wait bubble
//  NOP            out  1      to bubble mux: flush bubble
//  PC_write       out  1      PC register load enable
//  IFID_write     out  1      IF/ID register load enable
//  IFID_flush     out  1      IF/ID register clears to NOP on next edge
//  pipe_hold      out  1      freeze ID/EX, EX/MEM, MEM/WB
//  stall_cycles   out  CNT_W  cycles with Stall|pipe_hold (perf)
//  flush_count    out  CNT_W  redirects taken (perf)
// BEHAVIOUR
//  - lu = IDEX_MemRead & (IDEX_rd!=0) & ((IFID_use_rs1 & IFID_rs1==IDEX_rd) | (IFID_use_rs2 & IFID_rs2==IDEX_rd)).
//  - States:
//    RUN
//    IWAIT: fetch outstanding
//    DWAIT: data access outstanding
//  - Flag kill_pend: a wrong-path fetch is in flight.
//  - Priority each cycle: DM_stall > EX_redirect > IM_stall > lu.
//  - DM_stall=1 (any state) -> DWAIT.
//    - Outputs: pipe_hold=1, PC_write=0, IFID_write=0, Stall=0, NOP=0, IFID_flush=0.
//    - EX_redirect is ignored; EX is held, so the redirect is re-seen after release.
//  - EX_redirect=1 (DM_stall=0):
//    - Outputs: NOP=1, IFID_flush=1, PC_write=1 (PC loads target), IFID_write=1.
//    - If IM_stall=1 in the same cycle: set kill_pend, go to IWAIT.
//  - IM_stall=1 (no redirect):
//    - Go to / stay in IWAIT.
//    - Outputs: PC_write=0, IFID_write=0, Stall=1 (ID instruction must not issue twice); back end runs.
//  - IWAIT exit on the first cycle with IM_stall=0:
//    - kill_pend=1: IFID_flush=1, NOP=1, PC_write=1; clear kill_pend.
//    - kill_pend=0: normal RUN outputs.
//    - Next state is RUN.
//  - lu=1 in RUN (nothing higher active):
//    - Outputs: Stall=1, PC_write=0, IFID_write=0, for exactly one cycle.
//    - The bubble clears lu on the next cycle.
//  - RUN, no event: PC_write=1, IFID_write=1, all other outputs 0.
//  - Stall and NOP are never both 1.
//  - lu with a simultaneous redirect: the redirect wins; the ID instruction is flushed.
//  - State transitions occur on the rising edge.
//  - All outputs are combinational from state plus current inputs, so Stall/NOP reach the bubble mux in the same cycle.
//  - Reset (rst_n=0, asynchronous, any time including mid-wait):
//    - state=RUN, kill_pend=0, counters=0.
//    - Outputs forced while rst_n=0: PC_write=0, IFID_write=0, IFID_flush=1, NOP=1, Stall=0, pipe_hold=0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - stall_cycles increments each cycle Stall|pipe_hold.
//    - flush_count increments each accepted EX_redirect.
//    - Both saturate at all-ones and reset to 0.
//  HAZARD_PERF_CNT_EN undefined: no counter flops; stall_cycles and flush_count tied to 0.
// TESTING
//  1 load x5 in EX, ID reads rs2=x5, use_rs2=1 -> one cycle Stall=1, PC_write=0, IFID_write=0; next cycle all normal.
//  2 IDEX_rd=0, MemRead=1, rs1=0 -> no stall (x0 exempt).
//  3 IM_stall high 3 cycles, EX_redirect in cycle 1 -> cycle 1 NOP=1, PC_write=1; cycles 2-3 Stall=1;
//    first cycle IM_stall=0 -> IFID_flush=1, NOP=1; flush_count=1.
//  4 DM_stall 4 cycles with EX_redirect and lu high -> pipe_hold=1 for 4 cycles, NOP=Stall=0;
//    cycle after release -> redirect honored (NOP=1).
//  5 rst_n low mid-IWAIT with kill_pend=1 -> outputs forced to reset values at once;
//    after release state=RUN, no spurious flush.
//  6 HAZARD_PERF_CNT_EN on -> scenario 4 gives stall_cycles=4; off -> both counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Each cycle it picks Stall or NOP
//                for the ID/EX bubble mux and drives PC write-enable, IF/ID
//                write/flush and the back-end freeze. It covers load-use,
//                EX-resolved redirects, instruction-memory wait and data-memory
//                wait. It also remembers a wrong-path fetch that is still in
//                flight across an instruction-memory wait.
//                Optional performance counters are built when the macro
//                HAZARD_PERF_CNT_EN is defined. Otherwise they read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_use_rs1,
    input  logic             IFID_use_rs2,
    input  logic             EX_redirect,
    input  logic             IM_stall,
    input  logic             DM_stall,
    output logic             Stall,
    output logic             NOP,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_IWAIT = 2'd1;
    localparam logic [1:0] S_DWAIT = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_nextState;
    logic       r_killPend;
    logic       w_nextKill;
    logic       w_loadUse;
    logic       w_killExit;
    logic       w_redirAccept;

    // Load in EX whose destination feeds the ID instruction. x0 is never a hazard.
    assign w_loadUse = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                       ((IFID_use_rs1 && (IFID_rs1 == IDEX_rd)) ||
                        (IFID_use_rs2 && (IFID_rs2 == IDEX_rd)));

    // A pending wrong-path fetch only exists while waiting. It is discarded on the
    // first cycle the fetch is back, provided nothing of higher priority intervenes.
    assign w_killExit = r_killPend && (r_state != S_RUN);

    // A redirect only counts when the back end is not frozen. While EX is held,
    // the same redirect is seen again after the release.
    assign w_redirAccept = EX_redirect && !DM_stall;

    // State and wrong-path flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_killPend <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_killPend <= w_nextKill;
        end
    end

    // Next-state and control outputs by priority: DM wait > redirect > IM wait > load-use
    always_comb begin
        w_nextState = S_RUN;
        w_nextKill  = r_killPend;
        Stall       = 1'b0;
        NOP         = 1'b0;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        pipe_hold   = 1'b0;

        if (!rst_n) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IFID_flush  = 1'b1;
            NOP         = 1'b1;
            w_nextKill  = 1'b0;
        end else if (DM_stall) begin
            w_nextState = S_DWAIT;
            pipe_hold   = 1'b1;
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
        end else if (EX_redirect) begin
            NOP         = 1'b1;
            IFID_flush  = 1'b1;
            if (IM_stall) begin
                // The fetch now in flight belongs to the wrong path.
                w_nextKill  = 1'b1;
                w_nextState = S_IWAIT;
            end else begin
                w_nextKill  = 1'b0;
            end
        end else if (IM_stall) begin
            // Hold PC and IF/ID. The bubble stops the ID instruction from issuing twice.
            w_nextState = S_IWAIT;
            Stall       = 1'b1;
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
        end else if (w_killExit) begin
            // The returning instruction is from the wrong path, so it is dropped.
            NOP         = 1'b1;
            IFID_flush  = 1'b1;
            w_nextKill  = 1'b0;
        end else if (w_loadUse) begin
            Stall       = 1'b1;
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushCount;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if ((Stall || pipe_hold) && (r_stallCycles != {CNT_W{1'b1}}))
                r_stallCycles <= r_stallCycles + c_ONE;
            if (w_redirAccept && (r_flushCount != {CNT_W{1'b1}}))
                r_flushCount <= r_flushCount + c_ONE;
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;
`else
    logic w_unusedRedir;
    assign w_unusedRedir = w_redirAccept;
    assign stall_cycles  = '0;
    assign flush_count   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl. Control outputs
//                are packed as {Stall,NOP,PC_write,IFID_write,IFID_flush,
//                pipe_hold}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam int c_PERF = 1;
`else
    localparam int c_PERF = 0;
`endif

    localparam logic [5:0] c_RST  = 6'b010010;
    localparam logic [5:0] c_NORM = 6'b001100;
    localparam logic [5:0] c_STL  = 6'b100000;
    localparam logic [5:0] c_FLSH = 6'b011110;
    localparam logic [5:0] c_HOLD = 6'b000001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_rd;
    logic [4:0]       IFID_rs1;
    logic [4:0]       IFID_rs2;
    logic             IFID_use_rs1;
    logic             IFID_use_rs2;
    logic             EX_redirect;
    logic             IM_stall;
    logic             DM_stall;
    logic             Stall;
    logic             NOP;
    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int nChecks = 0;
    int nBad    = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_rd      (IDEX_rd),
        .IFID_rs1     (IFID_rs1),
        .IFID_rs2     (IFID_rs2),
        .IFID_use_rs1 (IFID_use_rs1),
        .IFID_use_rs2 (IFID_use_rs2),
        .EX_redirect  (EX_redirect),
        .IM_stall     (IM_stall),
        .DM_stall     (DM_stall),
        .Stall        (Stall),
        .NOP          (NOP),
        .PC_write     (PC_write),
        .IFID_write   (IFID_write),
        .IFID_flush   (IFID_flush),
        .pipe_hold    (pipe_hold),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, check the combinational outputs, then advance past the edge.
    task automatic cyc(input string tag, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic redir,
                       input logic ims, input logic dms, input logic [5:0] expOut);
        IDEX_MemRead = mr;  IDEX_rd = rd;
        IFID_rs1 = rs1;     IFID_rs2 = rs2;
        IFID_use_rs1 = u1;  IFID_use_rs2 = u2;
        EX_redirect = redir; IM_stall = ims; DM_stall = dms;
        #2;
        checkVal(tag, {26'd0, Stall, NOP, PC_write, IFID_write, IFID_flush, pipe_hold}, {26'd0, expOut});
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        checkVal("reset_outs", {26'd0, Stall, NOP, PC_write, IFID_write, IFID_flush, pipe_hold}, {26'd0, c_RST});
        checkVal("reset_stallcnt", stall_cycles, 32'd0);
        checkVal("reset_flushcnt", flush_count, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        IDEX_MemRead = 0; IDEX_rd = 0; IFID_rs1 = 0; IFID_rs2 = 0;
        IFID_use_rs1 = 0; IFID_use_rs2 = 0; EX_redirect = 0; IM_stall = 0; DM_stall = 0;
        #1;
        doReset();
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, c_NORM);

        // Load-use on rs2, then the bubble in EX clears the hazard.
        cyc("lu_rs2", 1, 5, 3, 5, 1, 1, 0, 0, 0, c_STL);
        cyc("lu_after", 0, 5, 3, 5, 1, 1, 0, 0, 0, c_NORM);
        cyc("lu_rs1", 1, 7, 7, 2, 1, 0, 0, 0, 0, c_STL);
        cyc("lu_nouse", 1, 5, 3, 5, 1, 0, 0, 0, 0, c_NORM);
        cyc("lu_x0", 1, 0, 0, 0, 1, 1, 0, 0, 0, c_NORM);

        // A redirect during a fetch wait, then a kill on the wait exit.
        cyc("redir_im1", 0, 0, 0, 0, 0, 0, 1, 1, 0, c_FLSH);
        cyc("iwait2", 0, 0, 0, 0, 0, 0, 0, 1, 0, c_STL);
        cyc("iwait3", 0, 0, 0, 0, 0, 0, 0, 1, 0, c_STL);
        cyc("iwait_kill", 0, 0, 0, 0, 0, 0, 0, 0, 0, c_FLSH);
        checkVal("flushcnt_s3", flush_count, c_PERF ? 32'd1 : 32'd0);
        cyc("after_kill", 0, 0, 0, 0, 0, 0, 0, 0, 0, c_NORM);
        cyc("iwait_plain", 0, 0, 0, 0, 0, 0, 0, 1, 0, c_STL);
        cyc("iwait_plain_exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, c_NORM);

        // A DM wait masks both a redirect and a load-use. The redirect is honored after release.
        doReset();
        for (int i = 0; i < 4; i++)
            cyc("dwait_hold", 1, 5, 5, 0, 1, 0, 1, 0, 1, c_HOLD);
        cyc("dwait_release", 1, 5, 5, 0, 1, 0, 1, 0, 0, c_FLSH);
        checkVal("stallcnt_s4", stall_cycles, c_PERF ? 32'd4 : 32'd0);
        checkVal("flushcnt_s4", flush_count, c_PERF ? 32'd1 : 32'd0);
        cyc("after_dwait", 0, 0, 0, 0, 0, 0, 0, 0, 0, c_NORM);

        // An asynchronous reset in the middle of a fetch wait while a kill is pending.
        cyc("s5_redir_im", 0, 0, 0, 0, 0, 0, 1, 1, 0, c_FLSH);
        IM_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_outs", {26'd0, Stall, NOP, PC_write, IFID_write, IFID_flush, pipe_hold}, {26'd0, c_RST});
        checkVal("async_rst_stallcnt", stall_cycles, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("s5_no_spurious", 0, 0, 0, 0, 0, 0, 0, 0, 0, c_NORM);
        cyc("s5_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, c_NORM);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
`default_nettype wire
